sw_port_arb: RTL and testbench



---
 rtl/sw_port_arb_pkg.sv | 28 ++
 rtl/sw_port_arb_rr_pick.sv | 40 ++++
 rtl/sw_port_arb.sv | 120 ++++++++++++
 tb/tb_sw_port_arb.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/sw_port_arb_pkg.sv
// rtl/sw_port_arb_pkg.sv - shared sizes, FSM encoding and flit type codes for the switch allocator
// The idle-release threshold below is only used when SA_IDLE_RELEASE_EN is defined.
package sw_port_arb_pkg;

  localparam int NPORT    = 5;
  localparam int NVC      = 2;
  localparam int NREQ     = NPORT * NVC;
  localparam int IDXW     = 4;
  localparam int IDLE_MAX = 15;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sa_state_e;

  typedef enum logic [1:0] {
    TYPE_HEAD     = 2'd0,
    TYPE_BODY     = 2'd1,
    TYPE_TAIL     = 2'd2,
    TYPE_HEADTAIL = 2'd3
  } flit_type_e;

  // Requester index successor; NREQ need not be a power of two.
  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
    return (i == IDXW'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/sw_port_arb_rr_pick.sv
// rtl/sw_port_arb_rr_pick.sv - combinational round-robin picker
// Picks the first unmasked request at or after start_i, wrapping at N-1.
module sw_port_arb_rr_pick
  import sw_port_arb_pkg::*;
#(
  parameter int N = NREQ,
  parameter int W = IDXW
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] mask_i,
  input  logic [W-1:0] start_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  logic [N-1:0] elig;
  logic [W:0]   cand;
  logic [W-1:0] cidx;

  always_comb begin
    elig    = req_i & ~mask_i;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    cidx    = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, start_i} + (W+1)'(i);
      if (cand >= (W+1)'(N)) cand = cand - (W+1)'(N);
      cidx = cand[W-1:0];
      if (!valid_o && elig[cidx]) begin
        valid_o     = 1'b1;
        idx_o       = cidx;
        gnt_o[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_port_arb.sv
// rtl/sw_port_arb.sv - per-output-port switch allocator, packet-granular round robin
// Optional SA_IDLE_RELEASE_EN forces release of an owner stalled for IDLE_MAX cycles.
module sw_port_arb
  import sw_port_arb_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] send_i,
  input  logic [NREQ-1:0] tail_i,
  output logic [NREQ-1:0] grt_o,
  output logic            busy_o,
  output logic [IDXW-1:0] owner_o
);

  sa_state_e       state_q;
  logic [NREQ-1:0] grt_q;
  logic            busy_q;
  logic [IDXW-1:0] owner_q;
  logic [IDXW-1:0] ptr_q;

  logic [IDXW-1:0] owner_nxt;
  logic            own_req, own_send, own_tail;
  logic            idle_rel_c;
  logic            release_c;

  logic [NREQ-1:0] pick_mask, pick_gnt;
  logic [IDXW-1:0] pick_start, pick_idx;
  logic            pick_valid;

  assign owner_nxt = next_idx(owner_q);
  assign own_req   = req_i[owner_q];
  assign own_send  = send_i[owner_q];
  assign own_tail  = tail_i[owner_q];
  assign release_c = (state_q == HOLD) && ((own_send && own_tail) || !own_req || idle_rel_c);

  // In HOLD the picker only matters in the release cycle, for a bubble-free handover.
  assign pick_start = (state_q == HOLD) ? owner_nxt : ptr_q;
  assign pick_mask  = (state_q == HOLD) ? (NREQ'(1) << owner_q) : '0;

  sw_port_arb_rr_pick #(.N(NREQ), .W(IDXW)) u_pick (
    .req_i   (req_i),
    .mask_i  (pick_mask),
    .start_i (pick_start),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

`ifdef SA_IDLE_RELEASE_EN
  localparam int CNTW = $clog2(IDLE_MAX + 1);
  logic [CNTW-1:0] idle_cnt_q, idle_cnt_d;
  logic            stall_c;

  assign stall_c    = (state_q == HOLD) && own_req && !own_send;
  assign idle_rel_c = stall_c && (idle_cnt_q == CNTW'(IDLE_MAX - 1));

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if ((state_q != HOLD) || release_c || own_send) idle_cnt_d = '0;
    else if (stall_c) idle_cnt_d = idle_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) idle_cnt_q <= '0;
    else       idle_cnt_q <= idle_cnt_d;
  end
`else
  assign idle_rel_c = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grt_q   <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q <= HOLD;
            grt_q   <= pick_gnt;
            busy_q  <= 1'b1;
            owner_q <= pick_idx;
          end
        end
        HOLD: begin
          if (release_c) begin
            ptr_q <= owner_nxt;
            if (pick_valid) begin
              grt_q   <= pick_gnt;
              owner_q <= pick_idx;
            end else begin
              state_q <= IDLE;
              grt_q   <= '0;
              busy_q  <= 1'b0;
              owner_q <= '0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          grt_q   <= '0;
          busy_q  <= 1'b0;
          owner_q <= '0;
        end
      endcase
    end
  end

  assign grt_o   = grt_q;
  assign busy_o  = busy_q;
  assign owner_o = owner_q;

  a_no_foreign_send: assert property (@(posedge clk_i) disable iff (rst_i) (send_i & ~grt_q) == '0);
  a_grant_shape:     assert property (@(posedge clk_i) $onehot0(grt_q) && (busy_q == |grt_q));

endmodule

// File: tb/tb_sw_port_arb.sv
// tb/tb_sw_port_arb.sv - self-checking bench for sw_port_arb (vector table + scoreboard)
module tb_sw_port_arb;
  import sw_port_arb_pkg::*;

  typedef struct {
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] send;
    logic [NREQ-1:0] tail;
    logic [NREQ-1:0] grt;
    logic [IDXW-1:0] own;
  } vec_t;

  typedef struct {
    logic [NREQ-1:0] grt;
    logic [IDXW-1:0] own;
    logic            busy;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req, send, tail;
  logic [NREQ-1:0] grt;
  logic            busy;
  logic [IDXW-1:0] owner;

  int   checks = 0;
  int   errors = 0;
  int   stepno = 0;
  vec_t tbl[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  sw_port_arb dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .send_i  (send),
    .tail_i  (tail),
    .grt_o   (grt),
    .busy_o  (busy),
    .owner_o (owner)
  );

  function automatic vec_t mk(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] sd,
                              input logic [NREQ-1:0] tl, input logic [NREQ-1:0] eg,
                              input logic [IDXW-1:0] eo);
    vec_t v;
    v.rst = r; v.req = rq; v.send = sd; v.tail = tl; v.grt = eg; v.own = eo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, stepno, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] sd,
                      input logic [NREQ-1:0] tl, input logic [NREQ-1:0] eg,
                      input logic [IDXW-1:0] eo);
    exp_t e;
    rst  = r;
    req  = rq;
    send = sd;
    tail = tl;
    sb.push_back('{eg, eo, |eg});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("grt",   32'(grt),   32'(e.grt));
      chk("owner", 32'(owner), 32'(e.own));
      chk("busy",  32'(busy),  32'(e.busy));
    end
    stepno++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = '0; send = '0; tail = '0;

    // reset with all requests, then ptr=0 picks 0
    tbl.push_back(mk(1'b1, 10'h3FF, 10'h000, 10'h000, 10'h000, 4'd0));
    tbl.push_back(mk(1'b0, 10'h3FF, 10'h000, 10'h000, 10'h001, 4'd0));
    tbl.push_back(mk(1'b0, 10'h000, 10'h000, 10'h000, 10'h000, 4'd0));
    // single requester 3, three flits, tail on the third
    tbl.push_back(mk(1'b0, 10'h008, 10'h000, 10'h000, 10'h008, 4'd3));
    tbl.push_back(mk(1'b0, 10'h008, 10'h008, 10'h000, 10'h008, 4'd3));
    tbl.push_back(mk(1'b0, 10'h008, 10'h008, 10'h000, 10'h008, 4'd3));
    tbl.push_back(mk(1'b0, 10'h008, 10'h008, 10'h008, 10'h000, 4'd0));
    tbl.push_back(mk(1'b0, 10'h000, 10'h000, 10'h000, 10'h000, 4'd0));
    // ptr=4 picks 5 over 3; req[1] rising mid-packet cannot preempt
    tbl.push_back(mk(1'b0, 10'h028, 10'h000, 10'h000, 10'h020, 4'd5));
    tbl.push_back(mk(1'b0, 10'h028, 10'h020, 10'h000, 10'h020, 4'd5));
    tbl.push_back(mk(1'b0, 10'h02A, 10'h020, 10'h000, 10'h020, 4'd5));
    tbl.push_back(mk(1'b0, 10'h02A, 10'h020, 10'h020, 10'h002, 4'd1));
    tbl.push_back(mk(1'b0, 10'h00A, 10'h002, 10'h002, 10'h008, 4'd3));
    tbl.push_back(mk(1'b0, 10'h008, 10'h008, 10'h008, 10'h000, 4'd0));
    // 2 and 7 alternate on HEADTAIL packets with no idle bubble
    tbl.push_back(mk(1'b0, 10'h004, 10'h000, 10'h000, 10'h004, 4'd2));
    tbl.push_back(mk(1'b0, 10'h084, 10'h004, 10'h004, 10'h080, 4'd7));
    tbl.push_back(mk(1'b0, 10'h084, 10'h080, 10'h080, 10'h004, 4'd2));
    tbl.push_back(mk(1'b0, 10'h084, 10'h004, 10'h004, 10'h080, 4'd7));
    tbl.push_back(mk(1'b0, 10'h080, 10'h080, 10'h080, 10'h000, 4'd0));
    tbl.push_back(mk(1'b0, 10'h000, 10'h000, 10'h000, 10'h000, 4'd0));
    // owner 9 hands over to 0 across the wrap, then reset mid-packet
    tbl.push_back(mk(1'b0, 10'h200, 10'h000, 10'h000, 10'h200, 4'd9));
    tbl.push_back(mk(1'b0, 10'h201, 10'h200, 10'h000, 10'h200, 4'd9));
    tbl.push_back(mk(1'b0, 10'h201, 10'h200, 10'h200, 10'h001, 4'd0));
    tbl.push_back(mk(1'b0, 10'h001, 10'h001, 10'h000, 10'h001, 4'd0));
    tbl.push_back(mk(1'b1, 10'h001, 10'h000, 10'h000, 10'h000, 4'd0));
    tbl.push_back(mk(1'b0, 10'h000, 10'h000, 10'h000, 10'h000, 4'd0));
    // release by req drop advances ptr; tail without send is ignored
    tbl.push_back(mk(1'b0, 10'h040, 10'h000, 10'h000, 10'h040, 4'd6));
    tbl.push_back(mk(1'b0, 10'h000, 10'h000, 10'h000, 10'h000, 4'd0));
    tbl.push_back(mk(1'b0, 10'h041, 10'h000, 10'h000, 10'h001, 4'd0));
    tbl.push_back(mk(1'b0, 10'h041, 10'h000, 10'h001, 10'h001, 4'd0));
    tbl.push_back(mk(1'b0, 10'h000, 10'h000, 10'h000, 10'h000, 4'd0));

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].rst, tbl[i].req, tbl[i].send, tbl[i].tail, tbl[i].grt, tbl[i].own);

    // stalled owner 4 with requester 6 waiting (ptr=1 here)
    step(1'b0, 10'h010, '0, '0, 10'h010, 4'd4);
`ifdef SA_IDLE_RELEASE_EN
    for (int j = 1; j <= IDLE_MAX; j++) begin
      if (j < IDLE_MAX) step(1'b0, 10'h050, '0, '0, 10'h010, 4'd4);
      else              step(1'b0, 10'h050, '0, '0, 10'h040, 4'd6);
    end
    step(1'b0, 10'h040, 10'h040, 10'h040, 10'h000, 4'd0);
`else
    for (int j = 1; j <= 100; j++)
      step(1'b0, 10'h050, '0, '0, 10'h010, 4'd4);
    step(1'b0, 10'h040, '0, '0, 10'h040, 4'd6);
    step(1'b0, 10'h040, 10'h040, 10'h040, 10'h000, 4'd0);
`endif

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
